i2c_regs: RTL and testbench

I2C_REGS -- requirements
Module: i2c_regs

---
 rtl/i2c_regs.sv | 138 +++++++++++++
 tb/tb_i2c_regs.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regs.sv
// rtl/i2c_regs.sv - I2C-addressable register file with a host-side port
//
// Sixteen 8-bit registers reachable from two sides:
//   - an I2C slave front end (ack/dir/dev/in/start/stop in, ok/out back),
//     using the usual "first byte is the register pointer" protocol with
//     auto-incrementing pointer for burst writes and reads;
//   - a simple host port (host_addr/host_wr/host_wdata, host_rdata).
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-low
//   ack         high while the I2C slave is in an acknowledge bit
//   dir         0 = master writes, 1 = master reads
//   dev         received device address
//   in          last received byte, stable while ack is high
//   start       one-cycle start / repeated-start pulse
//   stop        one-cycle stop pulse
//   ok          address match (dev == DEVADDR), combinational
//   out         byte to transmit next (reg[ptr]), combinational
//   host_addr   host register index
//   host_wr     host write strobe
//   host_wdata  host write data
//   host_rdata  reg[host_addr], combinational
//   i2c_we      one-cycle pulse per register written over I2C
//   i2c_waddr   index of that register, valid with i2c_we

module i2c_regs #(
   parameter logic [6:0] DEVADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ack,
   input  logic       dir,
   input  logic [6:0] dev,
   input  logic [7:0] in,
   input  logic       start,
   input  logic       stop,
   output logic       ok,
   output logic [7:0] out,
   input  logic [3:0] host_addr,
   input  logic       host_wr,
   input  logic [7:0] host_wdata,
   output logic [7:0] host_rdata,
   output logic       i2c_we,
   output logic [3:0] i2c_waddr
);

   // Byte position within the current transfer; saturates at ST_DATA.
   typedef enum logic [1:0] {
      ST_ADDR  = 2'd0,
      ST_FIRST = 2'd1,
      ST_DATA  = 2'd2
   } cnt_t;

   logic [7:0] regs [16];
   cnt_t       cnt;
   cnt_t       cnt_nxt;
   logic [3:0] ptr;
   logic [3:0] ptr_nxt;
   logic       ack_q;
   logic       ack_rise;
   logic       wr_i2c;

   assign ok         = (dev == DEVADDR);
   assign out        = regs[ptr];
   assign host_rdata = regs[host_addr];
   assign ack_rise   = ack & ~ack_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt       <= ST_ADDR;
         ptr       <= 4'd0;
         ack_q     <= 1'b0;
         i2c_we    <= 1'b0;
         i2c_waddr <= 4'd0;
      end else begin
         cnt    <= cnt_nxt;
         ptr    <= ptr_nxt;
         ack_q  <= ack;
         i2c_we <= wr_i2c;
         if (wr_i2c) begin
            i2c_waddr <= ptr;
         end
      end
   end

   // Start/stop dominate an ack edge on the same cycle: the transfer is
   // restarted and the ack is ignored.
   always_comb begin
      cnt_nxt = cnt;
      ptr_nxt = ptr;
      wr_i2c  = 1'b0;
      if (start || stop) begin
         cnt_nxt = ST_ADDR;
      end else if (ack_rise) begin
         case (cnt)
            ST_ADDR: begin
               cnt_nxt = ST_FIRST;
            end
            ST_FIRST: begin
               // Writes load the pointer from the low nibble; reads just
               // advance past the byte that was transmitted.
               if (dir) begin
                  ptr_nxt = ptr + 4'd1;
               end else begin
                  ptr_nxt = in[3:0];
               end
               cnt_nxt = ST_DATA;
            end
            ST_DATA: begin
               wr_i2c  = ~dir;
               ptr_nxt = ptr + 4'd1;
            end
            default: begin
               cnt_nxt = ST_ADDR;
            end
         endcase
      end
   end

   // The I2C write has priority over a host write to the same register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (wr_i2c && (ptr == 4'(i))) begin
               regs[i] <= in;
            end else if (host_wr && (host_addr == 4'(i))) begin
               regs[i] <= host_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_regs.sv
// tb/tb_i2c_regs.sv - self-checking bench for i2c_regs

module tb_i2c_regs;

   localparam logic [6:0] DEVADDR = 7'h50;

   logic       clk = 1'b0;
   logic       reset;
   logic       ack;
   logic       dir;
   logic [6:0] dev;
   logic [7:0] in;
   logic       start;
   logic       stop;
   logic       ok;
   logic [7:0] out;
   logic [3:0] host_addr;
   logic       host_wr;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       i2c_we;
   logic [3:0] i2c_waddr;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference model
   logic [7:0] mem [16];
   int         mptr;
   int         mbyte;   // bytes acknowledged since start/stop, saturating at 2

   i2c_regs #(.DEVADDR(DEVADDR)) dut (
      .clk        (clk),
      .reset      (reset),
      .ack        (ack),
      .dir        (dir),
      .dev        (dev),
      .in         (in),
      .start      (start),
      .stop       (stop),
      .ok         (ok),
      .out        (out),
      .host_addr  (host_addr),
      .host_wr    (host_wr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .i2c_we     (i2c_we),
      .i2c_waddr  (i2c_waddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mptr  = 0;
      mbyte = 0;
   endtask

   task automatic model_ack(input logic [7:0] b, input logic d, input logic st,
                            input logic hw, input logic [3:0] ha, input logic [7:0] hd,
                            output logic ewe, output logic [3:0] ewa);
      ewe = 1'b0;
      ewa = 4'd0;
      if (st) begin
         mbyte = 0;
      end else if (mbyte == 0) begin
         mbyte = 1;
      end else if (!d && mbyte == 1) begin
         mptr  = int'(b) % 16;
         mbyte = 2;
      end else if (!d) begin
         mem[mptr] = b;
         ewe       = 1'b1;
         ewa       = 4'(mptr);
         mptr      = (mptr + 1) % 16;
      end else begin
         mptr  = (mptr + 1) % 16;
         mbyte = 2;
      end
      if (hw && !(ewe && ha == ewa)) mem[ha] = hd;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      repeat (cycles) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mbyte = 0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      mbyte = 0;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      host_addr  = a;
      host_wdata = d;
      host_wr    = 1'b1;
      @(negedge clk);
      host_wr = 1'b0;
      mem[a]  = d;
      chk("host_write_rdata", int'(host_rdata), int'(mem[a]));
   endtask

   // One ack bit, held high for two cycles so a level-sensitive design would
   // act twice. Optional coincident start and host write.
   task automatic do_ack(input logic [7:0] b, input logic d, input logic st,
                         input logic hw, input logic [3:0] ha, input logic [7:0] hd,
                         output logic we_o, output logic [3:0] wa_o, output logic [7:0] out_o);
      logic       ewe;
      logic [3:0] ewa;
      @(negedge clk);
      in         = b;
      dir        = d;
      ack        = 1'b1;
      start      = st;
      host_wr    = hw;
      host_addr  = ha;
      host_wdata = hd;
      model_ack(b, d, st, hw, ha, hd, ewe, ewa);
      @(negedge clk);
      start   = 1'b0;
      host_wr = 1'b0;
      we_o    = i2c_we;
      wa_o    = i2c_waddr;
      out_o   = out;
      chk("ack_we", int'(i2c_we), int'(ewe));
      if (ewe) chk("ack_waddr", int'(i2c_waddr), int'(ewa));
      chk("ack_out", int'(out), int'(mem[mptr]));
      chk("ack_host_rdata", int'(host_rdata), int'(mem[ha]));
      @(negedge clk);
      chk("we_one_cycle", int'(i2c_we), 0);
      ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_regs(input string name);
      for (int i = 0; i < 16; i++) begin
         host_addr = 4'(i);
         #1;
         chk(name, int'(host_rdata), int'(mem[i]));
      end
   endtask

   typedef enum logic [2:0] {K_HOST, K_START, K_STOP, K_ACK, K_HREAD} kind_t;
   typedef struct {
      kind_t      k;
      logic [3:0] a;
      logic [7:0] d;
      logic       dir;
      logic       exp_we;
      logic [3:0] exp_wa;
      logic [7:0] exp_v;
   } vec_t;

   vec_t vec [20];

   initial begin
      logic       we_o;
      logic [3:0] wa_o;
      logic [7:0] out_o;

      vec[0]  = '{K_HOST,  4'd3,  8'h33, 1'b0, 1'b0, 4'd0,  8'h33};
      vec[1]  = '{K_HOST,  4'd4,  8'h44, 1'b0, 1'b0, 4'd0,  8'h44};
      vec[2]  = '{K_HOST,  4'd5,  8'h55, 1'b0, 1'b0, 4'd0,  8'h55};
      vec[3]  = '{K_HOST,  4'd0,  8'hA0, 1'b0, 1'b0, 4'd0,  8'hA0};
      // write burst to reg14/15, pointer wraps to 0
      vec[4]  = '{K_START, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00};
      vec[5]  = '{K_ACK,   4'd0,  8'hA0, 1'b0, 1'b0, 4'd0,  8'hA0};
      vec[6]  = '{K_ACK,   4'd0,  8'h0E, 1'b0, 1'b0, 4'd0,  8'h00};
      vec[7]  = '{K_ACK,   4'd0,  8'hAA, 1'b0, 1'b1, 4'd14, 8'h00};
      vec[8]  = '{K_ACK,   4'd0,  8'hBB, 1'b0, 1'b1, 4'd15, 8'hA0};
      vec[9]  = '{K_STOP,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00};
      // pointer set to 3 (upper nibble ignored), repeated start, read 3 acks
      vec[10] = '{K_START, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00};
      vec[11] = '{K_ACK,   4'd0,  8'hA0, 1'b0, 1'b0, 4'd0,  8'hA0};
      vec[12] = '{K_ACK,   4'd0,  8'hF3, 1'b0, 1'b0, 4'd0,  8'h33};
      vec[13] = '{K_START, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00};
      vec[14] = '{K_ACK,   4'd0,  8'hA1, 1'b1, 1'b0, 4'd0,  8'h33};
      vec[15] = '{K_ACK,   4'd0,  8'h00, 1'b1, 1'b0, 4'd0,  8'h44};
      vec[16] = '{K_ACK,   4'd0,  8'h00, 1'b1, 1'b0, 4'd0,  8'h55};
      vec[17] = '{K_STOP,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00};
      vec[18] = '{K_HREAD, 4'd14, 8'h00, 1'b0, 1'b0, 4'd0,  8'hAA};
      vec[19] = '{K_HREAD, 4'd15, 8'h00, 1'b0, 1'b0, 4'd0,  8'hBB};

      reset      = 1'b0;
      ack        = 1'b0;
      dir        = 1'b0;
      dev        = DEVADDR;
      in         = 8'h00;
      start      = 1'b0;
      stop       = 1'b0;
      host_addr  = 4'd0;
      host_wr    = 1'b0;
      host_wdata = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_we", int'(i2c_we), 0);
      chk("reset_waddr", int'(i2c_waddr), 0);
      chk("reset_out", int'(out), 0);
      reset = 1'b1;
      check_all_regs("reset_regs");

      // address match
      dev = DEVADDR;           #1; chk("ok_match", int'(ok), 1);
      dev = DEVADDR ^ 7'h01;   #1; chk("ok_mismatch_lsb", int'(ok), 0);
      dev = DEVADDR ^ 7'h40;   #1; chk("ok_mismatch_msb", int'(ok), 0);
      dev = DEVADDR;

      // directed vector table
      for (int i = 0; i < 20; i++) begin
         case (vec[i].k)
            K_HOST: begin
               host_write(vec[i].a, vec[i].d);
               chk("tbl_host", int'(host_rdata), int'(vec[i].exp_v));
            end
            K_START: do_start();
            K_STOP:  do_stop();
            K_ACK: begin
               do_ack(vec[i].d, vec[i].dir, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
               chk("tbl_we", int'(we_o), int'(vec[i].exp_we));
               if (vec[i].exp_we) chk("tbl_waddr", int'(wa_o), int'(vec[i].exp_wa));
               chk("tbl_out", int'(out_o), int'(vec[i].exp_v));
            end
            default: begin
               @(negedge clk);
               host_addr = vec[i].a;
               #1;
               chk("tbl_hread", int'(host_rdata), int'(vec[i].exp_v));
            end
         endcase
      end

      // collision, same register: I2C wins
      do_start();
      do_ack(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h22, 1'b0, 1'b0, 1'b1, 4'd2, 8'h11, we_o, wa_o, out_o);
      do_stop();
      host_addr = 4'd2; #1; chk("coll_same_reg2", int'(host_rdata), 8'h22);
      // collision, different registers: both land
      do_start();
      do_ack(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h22, 1'b0, 1'b0, 1'b1, 4'd7, 8'h11, we_o, wa_o, out_o);
      do_stop();
      host_addr = 4'd2; #1; chk("coll_diff_reg2", int'(host_rdata), 8'h22);
      host_addr = 4'd7; #1; chk("coll_diff_reg7", int'(host_rdata), 8'h11);

      // start coinciding with an ack edge
      host_write(4'd6, 8'h66);
      host_write(4'd12, 8'hC1);
      do_start();
      do_ack(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h06, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h5A, 1'b0, 1'b1, 1'b0, 4'd6, 8'h00, we_o, wa_o, out_o);
      chk("startack_no_we", int'(we_o), 0);
      chk("startack_reg6", int'(host_rdata), 8'h66);
      do_ack(8'h09, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      chk("startack_addr_ack_out", int'(out_o), 8'h66);
      do_ack(8'h0C, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      chk("startack_ptr_byte_out", int'(out_o), 8'hC1);
      do_stop();

      // reset during the data phase
      do_start();
      do_ack(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h77, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_reset(2);
      chk("rst_mid_we", int'(i2c_we), 0);
      chk("rst_mid_out", int'(out), 0);
      check_all_regs("rst_mid_regs");
      do_start();
      do_ack(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      do_ack(8'h09, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, we_o, wa_o, out_o);
      chk("rst_ptr_byte_no_we", int'(we_o), 0);
      do_ack(8'h9A, 1'b0, 1'b0, 1'b0, 4'd9, 8'h00, we_o, wa_o, out_o);
      chk("rst_first_data_we", int'(we_o), 1);
      chk("rst_first_data_waddr", int'(wa_o), 9);
      chk("rst_first_data_reg9", int'(host_rdata), 8'h9A);
      do_stop();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         int         sel;
         logic [3:0] ha;
         sel = int'($urandom_range(0, 99));
         ha  = 4'($urandom_range(0, 15));
         if (sel < 10) begin
            do_start();
         end else if (sel < 18) begin
            do_stop();
         end else if (sel < 20) begin
            do_reset(1);
            chk("rnd_reset_out", int'(out), 0);
         end else if (sel < 30) begin
            host_write(ha, 8'($urandom));
         end else begin
            if ($urandom_range(0, 1) == 0) ha = 4'(mptr);
            do_ack(8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 19) == 0),
                   1'($urandom_range(0, 3) == 0), ha, 8'($urandom),
                   we_o, wa_o, out_o);
         end
         if (n % 50 == 49) check_all_regs("rnd_regs");
      end
      check_all_regs("final_regs");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
